// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit 5-stage core: opcodes, decoded control
// bundle and the HLT drain state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_J    = 4'hC;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
    logic alu_src;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } halt_state_t;

endpackage

// File: rtl/halt_drain_fsm.sv
// Turns a stalled HLT in decode into a fixed-length pipeline drain followed
// by a sticky halted state; a flush during the drain cancels the HLT.
module halt_drain_fsm
  import cpu_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall_i,
  input  logic flush_i,
  input  logic is_hlt,
  output logic force_bubble,
  output logic halted
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  halt_state_t      r_state;
  halt_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_cnt    <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_halted <= (w_state_nxt == ST_HALTED);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    force_bubble = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        // A flushed HLT is wrong-path and must not start a drain.
        if (!flush_i && stall_i && is_hlt) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      ST_DRAIN: begin
        force_bubble = 1'b1;
        if (flush_i) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_HALTED: begin
        force_bubble = 1'b1;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign halted = r_halted;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decode fields, injects bubbles on
// stall/flush/drain, and reports halt after an HLT drains the pipeline.
module id_ex_stage_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int REG_W        = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [3:0]        id_opcode,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc_next,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic              id_mem_to_reg,
  input  logic              id_alu_src,
  output logic              ex_valid,
  output logic [3:0]        ex_opcode,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc_next,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic              halted
);

  logic              w_is_hlt;
  logic              w_force_bubble;
  logic              w_bubble;
  ctrl_t             w_id_ctrl;

  logic              r_valid;
  logic [3:0]        r_opcode;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic [REG_W-1:0]  r_rd;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc_next;
  ctrl_t             r_ctrl;

  assign w_is_hlt  = (id_opcode == OP_HLT);
  assign w_id_ctrl = {id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_alu_src};

  halt_drain_fsm #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_halt_drain_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .is_hlt      (w_is_hlt),
    .force_bubble(w_force_bubble),
    .halted      (halted)
  );

  // Bubbles zero every field so ex_rt/ex_mem_read can never fake a load-use hit.
  assign w_bubble = flush_i | w_force_bubble | stall_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_opcode  <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_pc_next <= '0;
      r_ctrl    <= '0;
    end else if (w_bubble) begin
      r_valid   <= 1'b0;
      r_opcode  <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_pc_next <= '0;
      r_ctrl    <= '0;
    end else begin
      r_valid   <= 1'b1;
      r_opcode  <= id_opcode;
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_rd      <= id_rd;
      r_rs_data <= id_rs_data;
      r_rt_data <= id_rt_data;
      r_imm     <= id_imm;
      r_pc_next <= id_pc_next;
      r_ctrl    <= w_id_ctrl;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_opcode     = r_opcode;
  assign ex_rs         = r_rs;
  assign ex_rt         = r_rt;
  assign ex_rd         = r_rd;
  assign ex_rs_data    = r_rs_data;
  assign ex_rt_data    = r_rt_data;
  assign ex_imm        = r_imm;
  assign ex_pc_next    = r_pc_next;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_write  = r_ctrl.mem_write;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign ex_alu_src    = r_ctrl.alu_src;

endmodule
